// File: rtl/spike_pkg.sv
// Shared definitions for the spike event encoder: default field widths and
// the event record layout {timestamp, isi} used by the encoder and its buffer.
package spike_pkg;

  localparam int TS_WIDTH_DEF  = 16;
  localparam int SPIKE_COUNT_W = 16;

  // Event record at the default width; buffer words are packed in the same
  // {timestamp, isi} order for any TS_WIDTH.
  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0] timestamp;
    logic [TS_WIDTH_DEF-1:0] isi;
  } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Event buffer for the spike encoder: power-of-two circular FIFO with a
// valid/ready read side. A write while full is accepted only when a read
// happens in the same cycle. Writes never bypass to the read side.
module spike_event_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  assign push     = wr_en & (~full | pop);
  // Head reads as zero while empty so the outputs are clean after reset.
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage array; data is not reset, emptiness is tracked by count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Spike event encoder: detects rising edges of the neuron spike flag,
// stamps each with a free-running timestamp and the inter-spike interval,
// and queues {timestamp, isi} records for a valid/ready consumer.
// Optional build macro SPIKE_ENC_REFRACTORY_EN adds a post-detection
// lockout of REFRACT_CYCLES enabled cycles.
module spike_event_encoder
  import spike_pkg::*;
#(
  parameter int TS_WIDTH       = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int REFRACT_CYCLES = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     spike_in,
  input  logic                     enable,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_WIDTH-1:0]      ev_timestamp,
  output logic [TS_WIDTH-1:0]      ev_isi,
  output logic                     overflow,
  output logic [SPIKE_COUNT_W-1:0] spike_count
);

  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [TS_WIDTH-1:0]   isi_cnt;
  logic                  spike_prev;
  logic                  edge_seen;
  logic                  detect;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [2*TS_WIDTH-1:0] head_word;

  function automatic logic [TS_WIDTH-1:0] sat_inc_isi(input logic [TS_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [SPIKE_COUNT_W-1:0] sat_inc_count(input logic [SPIKE_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign edge_seen = enable & spike_in & ~spike_prev;
  assign pop       = ev_valid & ev_ready;

`ifdef SPIKE_ENC_REFRACTORY_EN
  localparam int REFR_W = $clog2(REFRACT_CYCLES + 1);
  logic [REFR_W-1:0] refr_cnt;

  assign detect = edge_seen & (refr_cnt == '0);

  // Lockout timer: loaded on any detection, counts down on enabled cycles.
  always_ff @(posedge clock) begin
    if (reset)                    refr_cnt <= '0;
    else if (detect)              refr_cnt <= REFR_W'(REFRACT_CYCLES);
    else if (enable && refr_cnt != '0) refr_cnt <= refr_cnt - 1'b1;
  end
`else
  // Lockout length only matters when the refractory feature is built in.
  logic [31:0] unused_refract;
  assign unused_refract = 32'(REFRACT_CYCLES);
  assign detect = edge_seen;
`endif

  // Edge history tracks the raw flag every cycle, even while disabled.
  always_ff @(posedge clock) begin
    if (reset) spike_prev <= 1'b0;
    else       spike_prev <= spike_in;
  end

  // Timestamp wraps; ISI saturates and restarts at 1 after a detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_cnt  <= '0;
      isi_cnt <= '0;
    end else if (enable) begin
      ts_cnt  <= ts_cnt + 1'b1;
      isi_cnt <= detect ? TS_WIDTH'(1) : sat_inc_isi(isi_cnt);
    end
  end

  // Sticky overflow on a drop and saturating count of all detections.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow    <= 1'b0;
      spike_count <= '0;
    end else if (detect) begin
      spike_count <= sat_inc_count(spike_count);
      if (fifo_full && !pop) overflow <= 1'b1;
    end
  end

  spike_event_fifo #(
    .DATA_W (2*TS_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (detect),
    .wr_data  ({ts_cnt, isi_cnt}),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_valid (ev_valid),
    .rd_ready (ev_ready),
    .rd_data  (head_word)
  );

  assign {ev_timestamp, ev_isi} = head_word;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed testbench for spike_event_encoder: a default-width instance and
// a 4-bit timestamp instance for wrap and saturation behaviour.
module tb_spike_event_encoder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spike = 1'b0;
  logic        enable = 1'b1;
  logic        ready = 1'b0;
  logic        ev_valid;
  logic [15:0] ev_ts;
  logic [15:0] ev_isi;
  logic        overflow;
  logic [15:0] spike_count;

  logic        spike_w = 1'b0;
  logic        ready_w = 1'b0;
  logic        w_valid;
  logic [3:0]  w_ts;
  logic [3:0]  w_isi;
  logic        w_overflow;
  logic [15:0] w_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  spike_event_encoder #(.TS_WIDTH(16), .FIFO_DEPTH(4), .REFRACT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .spike_in(spike), .enable(enable),
    .ev_valid(ev_valid), .ev_ready(ready), .ev_timestamp(ev_ts), .ev_isi(ev_isi),
    .overflow(overflow), .spike_count(spike_count));

  spike_event_encoder #(.TS_WIDTH(4), .FIFO_DEPTH(4), .REFRACT_CYCLES(8)) dut_w (
    .clock(clock), .reset(reset), .spike_in(spike_w), .enable(enable),
    .ev_valid(w_valid), .ev_ready(ready_w), .ev_timestamp(w_ts), .ev_isi(w_isi),
    .overflow(w_overflow), .spike_count(w_count));

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) tick();
  endtask

  // After this returns, the next rising edge is cycle 0 (timestamp 0).
  task automatic do_reset();
    reset = 1'b1; spike = 1'b0; spike_w = 1'b0; ready = 1'b0; ready_w = 1'b0; enable = 1'b1;
    tick(); tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse(input int n);
    goto_cycle(n);
    spike = 1'b1;
    tick();
    spike = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", ev_valid); end
    tests_run++; if (ev_ts !== 16'd0) begin tests_failed++; $display("FAIL reset_ts: got %0d expected 0", ev_ts); end
    tests_run++; if (ev_isi !== 16'd0) begin tests_failed++; $display("FAIL reset_isi: got %0d expected 0", ev_isi); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    tests_run++; if (spike_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", spike_count); end
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1;
    goto_cycle(10);
    spike = 1'b1;
    tick();
    tests_run++; if (ev_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0b expected 1", ev_valid); end
    tests_run++; if (ev_ts !== 16'd10) begin tests_failed++; $display("FAIL single_ts: got %0d expected 10", ev_ts); end
    tests_run++; if (ev_isi !== 16'd10) begin tests_failed++; $display("FAIL single_isi: got %0d expected 10", ev_isi); end
    tick();
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL single_popped: got %0b expected 0", ev_valid); end
    tick();
    spike = 1'b0;
    tick();
    tests_run++; if (spike_count !== 16'd1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", spike_count); end
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL single_held_no_event: got %0b expected 0", ev_valid); end
  endtask

  task automatic test_two_events();
    do_reset();
    pulse(10);
    pulse(30);
    tick(); tick(); tick();
    tests_run++; if (ev_ts !== 16'd10) begin tests_failed++; $display("FAIL two_head_ts: got %0d expected 10", ev_ts); end
    tests_run++; if (ev_isi !== 16'd10) begin tests_failed++; $display("FAIL two_head_isi: got %0d expected 10", ev_isi); end
    tests_run++; if (spike_count !== 16'd2) begin tests_failed++; $display("FAIL two_count: got %0d expected 2", spike_count); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run++; if (ev_ts !== 16'd30) begin tests_failed++; $display("FAIL two_second_ts: got %0d expected 30", ev_ts); end
    tests_run++; if (ev_isi !== 16'd20) begin tests_failed++; $display("FAIL two_second_isi: got %0d expected 20", ev_isi); end
    tick();
    tests_run++; if (ev_valid !== 1'b1) begin tests_failed++; $display("FAIL two_hold_valid: got %0b expected 1", ev_valid); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL two_drained: got %0b expected 0", ev_valid); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ts [4];
    exp_ts[0] = 16'd30; exp_ts[1] = 16'd50; exp_ts[2] = 16'd70; exp_ts[3] = 16'd130;
    do_reset();
    pulse(10); pulse(30); pulse(50); pulse(70);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_after4: got %0b expected 0", overflow); end
    pulse(90);
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_after5: got %0b expected 1", overflow); end
    pulse(110);
    tests_run++; if (spike_count !== 16'd6) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 6", spike_count); end
    tests_run++; if (ev_ts !== 16'd10) begin tests_failed++; $display("FAIL ovf_head_ts: got %0d expected 10", ev_ts); end
    // Full buffer: detection coinciding with a pop must be kept.
    goto_cycle(130);
    spike = 1'b1;
    ready = 1'b1;
    tick();
    spike = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ev_valid !== 1'b1 || ev_ts !== exp_ts[i]) begin
        tests_failed++;
        $display("FAIL ovf_drain_%0d: got valid=%0b ts=%0d expected valid=1 ts=%0d", i, ev_valid, ev_ts, exp_ts[i]);
      end
      if (i == 3) begin
        tests_run++; if (ev_isi !== 16'd20) begin tests_failed++; $display("FAIL ovf_pushpop_isi: got %0d expected 20", ev_isi); end
      end
      tick();
    end
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty: got %0b expected 0", ev_valid); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    tests_run++; if (spike_count !== 16'd7) begin tests_failed++; $display("FAIL ovf_count7: got %0d expected 7", spike_count); end
    // Empty buffer with ready already high: no bypass, event shows next cycle.
    goto_cycle(150);
    spike = 1'b1;
    tick();
    spike = 1'b0;
    tests_run++; if (ev_valid !== 1'b1 || ev_ts !== 16'd150) begin tests_failed++; $display("FAIL nobypass: got valid=%0b ts=%0d expected valid=1 ts=150", ev_valid, ev_ts); end
    tick();
    ready = 1'b0;
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL nobypass_pop: got %0b expected 0", ev_valid); end
  endtask

  task automatic test_enable();
    do_reset();
    goto_cycle(5);
    enable = 1'b0;
    goto_cycle(7);
    spike = 1'b1;
    goto_cycle(10);
    enable = 1'b1;
    tick();
    spike = 1'b0;
    tests_run++; if (spike_count !== 16'd0 || ev_valid !== 1'b0) begin tests_failed++; $display("FAIL enable_no_detect: got count=%0d valid=%0b expected count=0 valid=0", spike_count, ev_valid); end
    goto_cycle(13);
    spike = 1'b1;
    tick();
    spike = 1'b0;
    // Cycles 5..9 were frozen, so the stamp at cycle 13 is 13-5.
    tests_run++; if (ev_ts !== 16'd8) begin tests_failed++; $display("FAIL enable_ts: got %0d expected 8", ev_ts); end
    tests_run++; if (ev_isi !== 16'd8) begin tests_failed++; $display("FAIL enable_isi: got %0d expected 8", ev_isi); end
  endtask

  task automatic test_refractory();
    do_reset();
    pulse(10);
    pulse(14);
    tick();
`ifdef SPIKE_ENC_REFRACTORY_EN
    tests_run++; if (spike_count !== 16'd1) begin tests_failed++; $display("FAIL refr_count: got %0d expected 1", spike_count); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run++; if (ev_valid !== 1'b0) begin tests_failed++; $display("FAIL refr_single: got %0b expected 0", ev_valid); end
`else
    tests_run++; if (spike_count !== 16'd2) begin tests_failed++; $display("FAIL refr_count: got %0d expected 2", spike_count); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run++; if (ev_ts !== 16'd14) begin tests_failed++; $display("FAIL refr_second_ts: got %0d expected 14", ev_ts); end
    tests_run++; if (ev_isi !== 16'd4) begin tests_failed++; $display("FAIL refr_second_isi: got %0d expected 4", ev_isi); end
`endif
  endtask

  task automatic test_wrap_and_flush();
    do_reset();
    goto_cycle(18);
    spike_w = 1'b1;
    tick();
    spike_w = 1'b0;
    tests_run++; if (w_ts !== 4'd2) begin tests_failed++; $display("FAIL wrap_ts: got %0d expected 2", w_ts); end
    tests_run++; if (w_isi !== 4'd15) begin tests_failed++; $display("FAIL wrap_isi_sat: got %0d expected 15", w_isi); end
    goto_cycle(22); spike_w = 1'b1; tick(); spike_w = 1'b0;
    goto_cycle(26); spike_w = 1'b1; tick(); spike_w = 1'b0;
    tests_run++; if (w_count !== 16'd3 || w_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_three: got count=%0d valid=%0b expected count=3 valid=1", w_count, w_valid); end
    // Reset pulse with a coincident rising edge: reset must win.
    goto_cycle(30);
    reset = 1'b1;
    spike_w = 1'b1;
    tick();
    reset = 1'b0;
    spike_w = 1'b0;
    tests_run++; if (w_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %0b expected 0", w_valid); end
    tests_run++; if (w_overflow !== 1'b0) begin tests_failed++; $display("FAIL flush_ovf: got %0b expected 0", w_overflow); end
    tests_run++; if (w_count !== 16'd0) begin tests_failed++; $display("FAIL flush_count: got %0d expected 0", w_count); end
    tests_run++; if (w_ts !== 4'd0) begin tests_failed++; $display("FAIL flush_ts: got %0d expected 0", w_ts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_events();
    test_overflow();
    test_enable();
    test_refractory();
    test_wrap_and_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  // Unused helper kept out: all comparisons are inline in the test tasks.
  initial if (0) chk("none", 0, 0);

endmodule

// File: doc/spike_event_encoder.md
SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter TS_WIDTH, default 16, width of timestamp and inter-spike-interval (ISI) fields.
REQ-002 Parameter FIFO_DEPTH, default 4, event buffer entries (power of two, >=2).
REQ-003 Parameter REFRACT_CYCLES, default 8, refractory lockout length in clock cycles.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 spike_in  input  1  level spike flag from the neuron membrane stage.
REQ-007 enable  input  1  when low: timestamp frozen, no event detection.
REQ-008 ev_valid  output  1  event available at head of buffer.
REQ-009 ev_ready  input  1  consumer accepts head event.
REQ-010 ev_timestamp  output  TS_WIDTH  timestamp of head event.
REQ-011 ev_isi  output  TS_WIDTH  ISI of head event.
REQ-012 overflow  output  1  sticky: an event was dropped because the buffer was full.
REQ-013 spike_count  output  16  saturating count of detected events.

Function
REQ-014 Timestamp counter SHALL increment by 1 each cycle enable=1, wrapping from 2^TS_WIDTH-1 to 0.
REQ-015 spike_in SHALL be registered into spike_prev every cycle, regardless of enable.
REQ-016 Detection SHALL occur in a cycle where enable=1, spike_in=1, spike_prev=0 (rising edge only); a held-high spike produces one event.
REQ-017 ISI counter SHALL count cycles with enable=1 since the last detection, saturating at all-ones; it resets to 1 in the detection cycle's following count; first event after reset reports ISI = cycles since reset, saturated.
REQ-018 On detection at edge N, {current timestamp, ISI} SHALL be written to the buffer at edge N; ev_valid SHALL be high after edge N if the buffer was empty (1-cycle latency).
REQ-019 Head entry SHALL pop at an edge where ev_valid=1 and ev_ready=1; ev_timestamp/ev_isi SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-020 Detection with buffer full and no pop that cycle SHALL drop the event and set overflow; overflow clears only on reset.
REQ-021 Detection with buffer full and a pop in the same cycle SHALL be accepted (no drop, no overflow).
REQ-022 Simultaneous push and pop with buffer empty SHALL not bypass: event appears at ev_valid the next cycle.
REQ-023 spike_count SHALL increment on every detection, including dropped events, saturating at 16'hFFFF.
REQ-024 ev_ready asserted with ev_valid=0 SHALL have no effect.

Reset
REQ-025 On reset: timestamp=0, ISI counter=0, spike_prev=0, buffer empty, ev_valid=0, ev_timestamp=0, ev_isi=0, overflow=0, spike_count=0, refractory counter=0.
REQ-026 Reset asserted mid-operation SHALL flush all buffered events with no pop handshake; reset takes priority over a simultaneous detection or pop.

Configuration
REQ-027 Macro SPIKE_ENC_REFRACTORY_EN defined: after an accepted or dropped detection, rising edges SHALL be ignored (not buffered, not counted, ISI not reset) for the next REFRACT_CYCLES enabled cycles.
REQ-028 Macro undefined: no lockout; every rising edge per REQ-016 is a detection; REFRACT_CYCLES is unused.

Structure
REQ-029 Shared package spike_pkg SHALL hold TS_WIDTH default, spike_count width (16), and the event record typedef {timestamp, isi}.
REQ-030 Buffer SHALL be a sub-module spike_event_fifo (depth-parameterised, valid/ready read side, full/empty flags); edge detect, timers and refractory logic stay in the top.

Verification
REQ-031 Reset, enable=1, spike_in rises at cycle 10 for 3 cycles, ev_ready=1 -> one event, ev_timestamp=10, ev_isi=10, spike_count=1.
REQ-032 Rising edges at cycles 10 and 30, ev_ready=0 -> two entries; second ev_isi=20; head stays ts=10 until ev_ready.
REQ-033 ev_ready=0, 6 rising edges 20 cycles apart with FIFO_DEPTH=4 -> 4 events held, overflow=1 after 5th, spike_count=6.
REQ-034 With SPIKE_ENC_REFRACTORY_EN, edges at cycles 10 and 14 (REFRACT_CYCLES=8) -> only ts=10 event, spike_count=1; without macro -> two events, ev_isi=4.
REQ-035 Timestamp wrap: TS_WIDTH=4, edge at cycle 18 -> ev_timestamp=2; buffer 3 entries then reset pulse -> ev_valid=0, overflow=0, spike_count=0 next cycle.
